// File: rtl/btn_debounce_repeat_pkg.sv
// btn_debounce_repeat_pkg: state encodings, default 100 MHz cycle counts, bench-sized cycle counts and max3 helper for counter sizing (BTN_AUTO_REPEAT_EN)
package btn_debounce_repeat_pkg;
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_HELD         = 3'd2;
  localparam logic [2:0] ST_REPEAT       = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;
  localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYC = 50_000_000;
  localparam int DEF_REPEAT_RATE_CYC  = 10_000_000;
  localparam int SIM_DEBOUNCE_CYC     = 4;
  localparam int SIM_REPEAT_DELAY_CYC = 20;
  localparam int SIM_REPEAT_RATE_CYC  = 8;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel -- clk, reset (async, active-high), btn_in raw -> 2-FF sync, debounce/repeat FSM, registered btn_level/btn_pulse/btn_release; repeat state only with BTN_AUTO_REPEAT_EN
module btn_debounce_ch
  import btn_debounce_repeat_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
`ifdef BTN_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC = DEF_REPEAT_RATE_CYC,
  parameter int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC))
`else
  parameter int CNT_W = $clog2(DEBOUNCE_CYC)
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYC - 1);
`endif
  logic [1:0] sync_q, sync_d;
  logic [2:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, pulse_q, pulse_d, release_q, release_d;
  logic s;
  assign s = sync_q[1];
  assign sync_d = {sync_q[0], btn_in};
  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign btn_release = release_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      release_q <= release_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        state_d = s ? ST_PRESS_WAIT : ST_IDLE;
      end
      ST_PRESS_WAIT: begin
        if (!s || cnt_q == DEB_LAST) cnt_d = '0;
        if (!s) state_d = ST_IDLE;
        else if (cnt_q == DEB_LAST) state_d = ST_HELD;
      end
`ifdef BTN_AUTO_REPEAT_EN
      ST_HELD: begin
        if (!s || cnt_q == DLY_LAST) cnt_d = '0;
        if (!s) state_d = ST_RELEASE_WAIT;
        else if (cnt_q == DLY_LAST) state_d = ST_REPEAT;
      end
      ST_REPEAT: begin
        if (!s || cnt_q == RATE_LAST) cnt_d = '0;
        if (!s) state_d = ST_RELEASE_WAIT;
      end
`else
      ST_HELD: begin
        cnt_d = '0;
        state_d = s ? ST_HELD : ST_RELEASE_WAIT;
      end
`endif
      ST_RELEASE_WAIT: begin
        if (s || cnt_q == DEB_LAST) cnt_d = '0;
        if (s) state_d = ST_HELD;
        else if (cnt_q == DEB_LAST) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_comb begin
    level_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) || (state_d == ST_RELEASE_WAIT);
    release_d = (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
`ifdef BTN_AUTO_REPEAT_EN
    pulse_d = ((state_q == ST_PRESS_WAIT) && (state_d == ST_HELD)) || ((state_d == ST_REPEAT) && (cnt_d == '0));
`else
    pulse_d = (state_q == ST_PRESS_WAIT) && (state_d == ST_HELD);
`endif
  end
endmodule

// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat: N_BTN independent channels -- clk, reset (async, active-high), btn_in[N_BTN] raw -> btn_level/btn_pulse/btn_release[N_BTN]; hold-to-repeat with BTN_AUTO_REPEAT_EN
module btn_debounce_repeat
  import btn_debounce_repeat_pkg::*;
#(
  parameter int N_BTN = 2,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC = DEF_REPEAT_RATE_CYC,
`ifdef BTN_AUTO_REPEAT_EN
  parameter int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC))
`else
  parameter int CNT_W = $clog2(DEBOUNCE_CYC)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);
`ifndef BTN_AUTO_REPEAT_EN
  localparam int unused_repeat_cfg = REPEAT_DELAY_CYC + REPEAT_RATE_CYC;
`endif
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
`ifdef BTN_AUTO_REPEAT_EN
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC(REPEAT_RATE_CYC),
`endif
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i]),
      .btn_release(btn_release[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce_repeat.sv
// tb_btn_debounce_repeat: directed and random stimulus checked against a run-length/timer model of btn_debounce_repeat
module tb_btn_debounce_repeat;
  localparam int N = 2, D = 4, RD = 20, RR = 8;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_pulse, btn_release;
  logic [N-1:0] el = '0, ep = '0, er = '0;
  bit m1[N], m2[N], first[N];
  int run[N], since[N];
  int n_chk = 0, n_pass = 0;
  wire [3*N-1:0] obs = {btn_level, btn_pulse, btn_release};
  wire [3*N-1:0] expv = {el, ep, er};
  always #5 clk = ~clk;
  btn_debounce_repeat #(
    .N_BTN(N),
    .DEBOUNCE_CYC(D),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_release(btn_release)
  );
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m1[i] = 0; m2[i] = 0; run[i] = 0; since[i] = 0; first[i] = 0;
    end
    el = '0; ep = '0; er = '0;
  endtask
  // A level change is accepted once the synchronised input has disagreed with the level for D+1 edges.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      bit s;
      s = m2[i]; m2[i] = m1[i]; m1[i] = btn_in[i];
      ep[i] = 1'b0; er[i] = 1'b0;
      if (reset) begin
        m1[i] = 0; m2[i] = 0; run[i] = 0; el[i] = 1'b0;
      end else if (s != el[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          el[i] = s; ep[i] = s; er[i] = !s; run[i] = 0; since[i] = 0; first[i] = 1;
        end
      end else begin
        if (el[i] && run[i] > 0) begin
          since[i] = 0; first[i] = 1;
        end else if (el[i] && REP) begin
          since[i]++;
          if (since[i] == (first[i] ? RD : RR)) begin
            ep[i] = 1'b1; since[i] = 0; first[i] = 0;
          end
        end
        run[i] = 0;
      end
    end
    #1;
  endtask
  task automatic settle();
    btn_in = '0;
    repeat (12) step();
  endtask
  task automatic test_reset();
    repeat (2) step();
    n_chk++; if (obs !== '0) $display("FAIL reset_hold: got %b want 0", obs); else n_pass++;
    reset = 1'b0;
    repeat (3) step();
    n_chk++; if (obs !== expv) $display("FAIL reset_release: got %b want %b", obs, expv); else n_pass++;
  endtask
  task automatic test_clean_press();
    btn_in[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_chk++; if (obs !== expv) $display("FAIL clean_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      n_chk++; if (btn_pulse[0] !== (c == 7) || btn_level[0] !== (c >= 7)) $display("FAIL clean_press c=%0d: pulse=%b level=%b want %0d %0d", c, btn_pulse[0], btn_level[0], c == 7, c >= 7); else n_pass++;
    end
    btn_in[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_chk++; if (obs !== expv) $display("FAIL clean_rel_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      n_chk++; if (btn_release[0] !== (c == 7) || btn_level[0] !== (c < 7)) $display("FAIL clean_release c=%0d: release=%b level=%b want %0d %0d", c, btn_release[0], btn_level[0], c == 7, c < 7); else n_pass++;
    end
  endtask
  task automatic test_bounce_reject();
    for (int c = 0; c < 20; c++) begin
      btn_in[0] = (c < 8) && ((c / 2) % 2 == 0);
      step();
      n_chk++; if (obs !== expv) $display("FAIL bounce_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      n_chk++; if (btn_pulse[0] !== 1'b0 || btn_level[0] !== 1'b0) $display("FAIL bounce_reject c=%0d: pulse=%b level=%b want 0 0", c, btn_pulse[0], btn_level[0]); else n_pass++;
    end
  endtask
  task automatic test_auto_repeat();
    int w, q[$], e[$];
    w = 0;
    btn_in[1] = 1'b1;
    while (!btn_pulse[1] && w < 20) begin step(); w++; end
    n_chk++; if (btn_pulse[1] !== 1'b1 || w != 7) $display("FAIL repeat_press: pulse=%b after %0d cycles want 1 after 7", btn_pulse[1], w); else n_pass++;
    for (int c = 1; c <= 59; c++) begin
      step();
      n_chk++; if (obs !== expv) $display("FAIL repeat_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      if (btn_pulse[1]) q.push_back(c);
    end
    if (REP) e = '{20, 28, 36, 44, 52};
    n_chk++; if (q.size() != e.size()) $display("FAIL repeat_count: got %0d pulses want %0d", q.size(), e.size()); else n_pass++;
    for (int i = 0; i < q.size() && i < e.size(); i++) begin
      n_chk++; if (q[i] != e[i]) $display("FAIL repeat_time[%0d]: got +%0d want +%0d", i, q[i], e[i]); else n_pass++;
    end
    btn_in[1] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_chk++; if (obs !== expv) $display("FAIL repeat_rel_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      n_chk++; if (btn_release[1] !== (c == 7)) $display("FAIL repeat_release c=%0d: release=%b want %0d", c, btn_release[1], c == 7); else n_pass++;
    end
    n_chk++; if (btn_level[1] !== 1'b0) $display("FAIL repeat_level_end: level=%b want 0", btn_level[1]); else n_pass++;
  endtask
  task automatic test_release_bounce();
    int w;
    w = 0;
    btn_in[0] = 1'b1;
    while (!btn_pulse[0] && w < 20) begin step(); w++; end
    n_chk++; if (btn_pulse[0] !== 1'b1) $display("FAIL rb_press_timeout: pulse=%b want 1", btn_pulse[0]); else n_pass++;
    repeat (5) step();
    btn_in[0] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) btn_in[0] = 1'b1;
      step();
      n_chk++; if (obs !== expv) $display("FAIL rb_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      n_chk++; if (btn_release[0] !== 1'b0 || btn_level[0] !== 1'b1 || btn_pulse[0] !== (REP && c == 25)) $display("FAIL release_bounce c=%0d: rel=%b lvl=%b pulse=%b want 0 1 %0d", c, btn_release[0], btn_level[0], btn_pulse[0], REP && c == 25); else n_pass++;
    end
    settle();
  endtask
  task automatic test_reset_mid_hold();
    int w;
    w = 0;
    btn_in[1] = 1'b1;
    while (!btn_pulse[1] && w < 20) begin step(); w++; end
    repeat (25) step();
    n_chk++; if (btn_level[1] !== 1'b1) $display("FAIL rst_pre_level: level=%b want 1", btn_level[1]); else n_pass++;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (obs !== '0) $display("FAIL rst_async: got %b want 0", obs); else n_pass++;
    repeat (2) step();
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_chk++; if (obs !== expv) $display("FAIL rst_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
      n_chk++; if (btn_pulse[1] !== (c == 7)) $display("FAIL rst_repress c=%0d: pulse=%b want %0d", c, btn_pulse[1], c == 7); else n_pass++;
    end
    settle();
  endtask
  task automatic test_simultaneous();
    btn_in = '1;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_chk++; if (btn_pulse !== ((c == 7) ? 2'b11 : 2'b00)) $display("FAIL simultaneous c=%0d: pulse=%b want %b", c, btn_pulse, (c == 7) ? 2'b11 : 2'b00); else n_pass++;
    end
    settle();
  endtask
  task automatic test_random();
    int left[N];
    for (int i = 0; i < N; i++) left[i] = 1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        left[i]--;
        if (left[i] <= 0) begin
          btn_in[i] = ~btn_in[i];
          left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 6));
        end
      end
      step();
      n_chk++; if (obs !== expv) $display("FAIL random_model c=%0d: got %b want %b", c, obs, expv); else n_pass++;
    end
    settle();
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_auto_repeat();
    test_release_bounce();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
